// File: rtl/byte_ser_pkg.sv
// byte_ser_pkg: shared FSM state type and width limit for byte_serializer (no ports; optional parity via BYTE_SER_PARITY_EN)
package byte_ser_pkg;
  localparam int MAX_WIDTH = 32;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} ser_state_t;
endpackage

// File: rtl/byte_serializer_if.sv
// byte_serializer_if: word-in/bit-out bundle; master drives din/din_valid, slave drives din_ready/sout/sout_valid/busy
interface byte_serializer_if #(parameter int WIDTH = 8) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  modport master (output din, din_valid, input din_ready, sout, sout_valid, busy);
  modport slave  (input din, din_valid, output din_ready, sout, sout_valid, busy);
endinterface

// File: rtl/byte_serializer_parity_calc.sv
// parity_calc: combinational even parity (XOR-reduce) of i_data[WIDTH-1:0] onto o_parity; used only when BYTE_SER_PARITY_EN is defined
module parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);
  assign o_parity = ^i_data;
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: parallel word to serial stream; ports clk, rst (sync active-high), bus (slave: din, din_valid, din_ready, sout, sout_valid, busy); BYTE_SER_PARITY_EN appends an even-parity bit per word
module byte_serializer
  import byte_ser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  byte_serializer_if.slave    bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  ser_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_sout_valid;
  logic             w_last;
  logic             w_xfer;
  logic             w_first;
  logic             w_nbit;
  logic [WIDTH-1:0] w_next;
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  assign w_xfer  = bus.din_valid && bus.din_ready;
  assign w_next  = MSB_FIRST ? r_shift << 1 : r_shift >> 1;
  assign w_first = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
  assign w_nbit  = MSB_FIRST ? w_next[WIDTH-1] : w_next[0];
`ifdef BYTE_SER_PARITY_EN
  logic w_par;
  logic r_par;
  parity_calc #(.WIDTH(WIDTH)) u_parity (.i_data(bus.din), .o_parity(w_par));
  assign bus.din_ready = !rst && (r_state == S_IDLE || r_state == S_PARITY);
`else
  assign bus.din_ready = !rst && (r_state == S_IDLE || (r_state == S_SHIFT && w_last));
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
`ifdef BYTE_SER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_state      <= S_SHIFT;
      r_cnt        <= '0;
      r_shift      <= bus.din;
      r_sout       <= w_first;
      r_sout_valid <= 1'b1;
`ifdef BYTE_SER_PARITY_EN
      r_par        <= w_par;
`endif
    end else if (r_state == S_SHIFT && !w_last) begin
      r_cnt   <= r_cnt + 1'b1;
      r_shift <= w_next;
      r_sout  <= w_nbit;
`ifdef BYTE_SER_PARITY_EN
    end else if (r_state == S_SHIFT) begin
      r_state <= S_PARITY;
      r_cnt   <= '0;
      r_sout  <= r_par;
`endif
    end else begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
    end
  end
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed plus random stimulus on an MSB-first/idle-0 and an LSB-first/idle-1 instance, checked against a bit-stream model
module tb_byte_serializer;
`ifdef BYTE_SER_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [7:0] din = '0;
  always #5 clk = ~clk;
  byte_serializer_if #(.WIDTH(8)) bus0 ();
  byte_serializer_if #(.WIDTH(8)) bus1 ();
  assign bus0.din = din;
  assign bus0.din_valid = vld;
  assign bus1.din = din;
  assign bus1.din_valid = vld;
  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  int checks = 0;
  int failures = 0;
  logic [7:0] mw [2];
  int mi [2];
  bit mv [2];
  bit mr [2];
  bit msb [2] = '{1'b1, 1'b0};
  bit idl [2] = '{1'b0, 1'b1};
  logic [7:0] cap;
  int cap_n;
  int vcnt;
  bit cap_en = 1'b0;
  function automatic logic exp_bit(int d);
    logic [7:0] w = mw[d];
    int i = mi[d];
    return (i < 8) ? (msb[d] ? w[7-i] : w[i]) : ^w;
  endfunction
  function automatic logic exp_sout(int d);
    return mv[d] ? exp_bit(d) : idl[d];
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) mr[d] = !rst && (!mv[d] || mi[d] == L - 1);
    chk("d0_sout", 32'(bus0.sout), 32'(exp_sout(0)));
    chk("d0_valid", 32'(bus0.sout_valid), 32'(mv[0]));
    chk("d0_busy", 32'(bus0.busy), 32'(mv[0]));
    chk("d0_ready", 32'(bus0.din_ready), 32'(mr[0]));
    chk("d1_sout", 32'(bus1.sout), 32'(exp_sout(1)));
    chk("d1_valid", 32'(bus1.sout_valid), 32'(mv[1]));
    chk("d1_busy", 32'(bus1.busy), 32'(mv[1]));
    chk("d1_ready", 32'(bus1.din_ready), 32'(mr[1]));
    if (cap_en && bus0.sout_valid === 1'b1) begin
      if (cap_n < 8) cap = {cap[6:0], bus0.sout};
      cap_n++;
      vcnt++;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mv[d] = 1'b0;
        mi[d] = 0;
      end else if (vld && mr[d]) begin
        mv[d] = 1'b1;
        mi[d] = 0;
        mw[d] = din;
      end else if (mv[d] && mi[d] < L - 1) begin
        mi[d]++;
      end else begin
        mv[d] = 1'b0;
      end
    end
    #1;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0;
      mi[d] = 0;
      mw[d] = '0;
    end
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    cap = '0;
    cap_n = 0;
    vcnt = 0;
    cap_en = 1'b1;
    din = 8'b1010_0110;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    for (int t = 0; t < L + 2; t++) begin
      din = 8'($urandom);
      tick();
    end
    cap_en = 1'b0;
    chk("word_a6_bits", 32'(cap), 32'h0000_00a6);
    chk("word_a6_valid_cycles", 32'(vcnt), 32'(L));
    vld = 1'b1;
    for (int t = 0; t < 2 * L + 1; t++) begin
      din = (t < L) ? 8'hff : 8'h00;
      vld = (t < 2 * L);
      tick();
    end
    vld = 1'b0;
    tick();
    tick();
    din = 8'h07;
    vld = 1'b1;
    tick();
    din = 8'h3c;
    for (int t = 0; t < L + 1; t++) tick();
    vld = 1'b0;
    for (int t = 0; t < L + 1; t++) tick();
    din = 8'ha5;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < L; t++) tick();
    din = 8'h01;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    for (int t = 0; t < L + 2; t++) tick();
    rst = 1'b1;
    vld = 1'b1;
    din = 8'h5a;
    tick();
    rst = 1'b0;
    vld = 1'b0;
    tick();
    tick();
    for (int t = 0; t < 400; t++) begin
      din = 8'($urandom);
      vld = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;
    vld = 1'b0;
    for (int t = 0; t < L + 2; t++) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per word (2..32).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = transmit MSB first, 0 = transmit LSB first.
REQ-003 Parameter: IDLE_LEVEL, default 0, value driven on sout when no bit is being sent.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous to clk, active-high.
REQ-006 Port: din  input  WIDTH  parallel word to serialize.
REQ-007 Port: din_valid  input  1  din holds a word to transfer.
REQ-008 Port: din_ready  output  1  block can accept a word this cycle.
REQ-009 Port: sout  output  1  serial bit stream, one bit per clk; feeds the downstream sequence detector's sin.
REQ-010 Port: sout_valid  output  1  sout carries a data or parity bit this cycle.
REQ-011 Port: busy  output  1  a word is in flight (state not S_IDLE).

Function
REQ-012 Transfer SHALL occur on a rising edge where din_valid && din_ready; no other condition loads din.
REQ-013 FSM states SHALL be S_IDLE, S_SHIFT and S_PARITY; S_PARITY is reachable only when BYTE_SER_PARITY_EN is defined.
REQ-014 S_IDLE: din_ready = 1, sout = IDLE_LEVEL, sout_valid = 0; on transfer go to S_SHIFT.
REQ-015 sout and sout_valid SHALL be registered; the first bit of a word accepted at edge k SHALL appear in the cycle after edge k (latency 1).
REQ-016 S_SHIFT: one bit per cycle, order per MSB_FIRST, bit counter 0..WIDTH-1; din_ready = 0 except in the cycle presenting the last data bit (counter = WIDTH-1) when parity is compiled out.
REQ-017 End of word without parity: on the last-bit edge, a transfer reloads the shifter and stays in S_SHIFT with no gap cycle; otherwise go to S_IDLE.
REQ-018 With parity: after the last data bit go to S_PARITY for exactly one cycle, sout = even parity of the word (XOR of all WIDTH bits), sout_valid = 1, din_ready = 1; transfer there goes gapless to S_SHIFT, else to S_IDLE.
REQ-019 din changing while din_ready = 0 SHALL have no effect on the word in flight.
REQ-020 busy SHALL be 1 exactly when state is S_SHIFT or S_PARITY.

Reset
REQ-021 While rst = 1: state = S_IDLE, counter = 0, shifter = 0, sout = IDLE_LEVEL, sout_valid = 0, busy = 0, din_ready = 0.
REQ-022 rst mid-word SHALL discard the word in flight; no remaining bits or parity are emitted; the first edge after rst deasserts behaves as S_IDLE.
REQ-023 rst SHALL take priority over a simultaneous transfer; that word is not accepted.

Configuration
REQ-024 Macro BYTE_SER_PARITY_EN: defined -> each word is followed by one even-parity bit (WIDTH+1 valid cycles per word); undefined -> no S_PARITY logic, WIDTH valid cycles per word, and din_ready is asserted on the last data bit.

Structure
REQ-025 Package byte_ser_pkg SHALL hold the ser_state_t enum (S_IDLE, S_SHIFT, S_PARITY) and the constant for the maximum WIDTH.
REQ-026 Sub-module parity_calc (combinational XOR-reduce of WIDTH bits) SHALL be instantiated only under BYTE_SER_PARITY_EN; shifter, counter and FSM stay in byte_serializer.

Verification
REQ-027 WIDTH=8, MSB_FIRST=1, no parity, din=8'b1010_0110 accepted at edge 0 -> sout = 1,0,1,0,0,1,1,0 in cycles 1..8, sout_valid = 1 for those 8 cycles only.
REQ-028 din_valid held with 8'hFF then 8'h00 -> 16 contiguous valid cycles (8 ones, then 8 zeros), din_ready high only in cycles 8 and 16.
REQ-029 BYTE_SER_PARITY_EN, din=8'h07 -> bits 0,0,0,0,0,1,1,1 then parity 1; 9 valid cycles; next word starts in cycle 10 if offered.
REQ-030 rst pulsed for 1 cycle after 3 bits of 8'hA5 -> sout = IDLE_LEVEL and sout_valid = 0 from the reset edge on; no further bits of 8'hA5.
REQ-031 MSB_FIRST=0, IDLE_LEVEL=1, din=8'h01 -> sout = 1,0,0,0,0,0,0,0, then 1 with sout_valid = 0 when idle.
REQ-032 rst and transfer on the same edge -> word dropped; busy stays 0.
